// File: rtl/fir_tap_wr_ctrl.sv
// FIR tap-write controller: stages one coefficient set of TAP_NUM words in local RAM,
// checks the word count, then forwards it to the DDR write arbiter as one addressed burst.
module fir_tap_wr_ctrl #(
    parameter int                TAP_NUM    = 127,
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] DDR_BASE   = 'h0100_0000,
    parameter int                TAP_STRIDE = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fir_tap_wr_cmd_i,
    input  logic [31:0]       fir_tap_wr_addr_i,
    input  logic              fir_tap_wr_vld_i,
    input  logic [DATA_W-1:0] fir_tap_wr_data_i,
    output logic              wr_req_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    input  logic              wr_ack_i,
    output logic              wr_valid_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              wr_last_o,
    input  logic              wr_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_short_o,
    output logic              err_long_o,
    output logic              err_busy_o
);

    localparam int CNT_W = $clog2(TAP_NUM + 1);
    localparam int IDX_W = $clog2(TAP_NUM);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TAP_NUM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAP_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_REQ     = 2'd2,
        S_BURST   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                cmd_d1_q;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic                bad_q, bad_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [CNT_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic                rd_pend_q, rd_pend_d;
    logic                rd_last_q, rd_last_d;
    logic [DATA_W-1:0]   rd_data_q;
    logic [DATA_W-1:0]   ob0_data_q, ob0_data_d, ob1_data_q, ob1_data_d;
    logic                ob0_last_q, ob0_last_d, ob1_last_q, ob1_last_d;
    logic [1:0]          ob_cnt_q, ob_cnt_d;
    logic                done_q, done_d;
    logic                err_short_q, err_short_d;
    logic                err_long_q, err_long_d;
    logic                err_busy_q, err_busy_d;

    logic [DATA_W-1:0]   ram [TAP_NUM];
    logic                ram_we;
    logic                rd_issue;
    logic                pop;
    logic                cmd_rise, cmd_fall, word_in;

    assign cmd_rise = fir_tap_wr_cmd_i & ~cmd_d1_q;
    assign cmd_fall = ~fir_tap_wr_cmd_i & cmd_d1_q;
    // A word coinciding with the falling edge still belongs to the frame.
    assign word_in  = fir_tap_wr_vld_i & (fir_tap_wr_cmd_i | cmd_d1_q);

    assign wr_req_o    = (state_q == S_REQ);
    assign wr_addr_o   = wr_addr_q;
    assign wr_valid_o  = (state_q == S_BURST) && (ob_cnt_q != 2'd0);
    assign wr_data_o   = ob0_data_q;
    assign wr_last_o   = wr_valid_o & ob0_last_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign err_short_o = err_short_q;
    assign err_long_o  = err_long_q;
    assign err_busy_o  = err_busy_q;
    assign pop         = wr_valid_o & wr_ready_i;

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        bad_d       = bad_q;
        wr_addr_d   = wr_addr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_last_d   = rd_last_q;
        done_d      = 1'b0;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        err_busy_d  = 1'b0;
        ram_we      = 1'b0;
        rd_issue    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_rise) begin
                    wr_addr_d = DDR_BASE + ADDR_W'(fir_tap_wr_addr_i) * ADDR_W'(TAP_STRIDE);
                    wr_cnt_d  = '0;
                    bad_d     = 1'b0;
                    state_d   = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (word_in) begin
                    if (wr_cnt_q < CNT_FULL) begin
                        ram_we   = 1'b1;
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end else begin
                        err_long_d = 1'b1;
                        bad_d      = 1'b1;
                    end
                end
                if (cmd_fall) begin
                    rd_ptr_d = '0;
                    if (bad_d) begin
                        state_d = S_IDLE;
                    end else if (wr_cnt_d == CNT_FULL) begin
                        state_d = S_REQ;
                    end else begin
                        err_short_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_REQ: begin
                err_busy_d = cmd_rise;
                if (wr_ack_i) begin
                    rd_issue = 1'b1;
                    state_d  = S_BURST;
                end
            end
            S_BURST: begin
                err_busy_d = cmd_rise;
                // Keep buffered plus in-flight words within the two skid entries.
                rd_issue = (rd_ptr_q < CNT_FULL) &&
                           (int'(ob_cnt_q) + int'(rd_pend_q) - int'(pop) < 2);
                if (pop && ob0_last_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rd_pend_d = rd_issue;
        if (rd_issue) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_last_d = (rd_ptr_q == CNT_LAST);
        end

        ob0_data_d = ob0_data_q;
        ob0_last_d = ob0_last_q;
        ob1_data_d = ob1_data_q;
        ob1_last_d = ob1_last_q;
        ob_cnt_d   = ob_cnt_q;
        if (pop) begin
            ob0_data_d = ob1_data_q;
            ob0_last_d = ob1_last_q;
            ob_cnt_d   = ob_cnt_d - 2'd1;
        end
        if (rd_pend_q) begin
            if (ob_cnt_d == 2'd0) begin
                ob0_data_d = rd_data_q;
                ob0_last_d = rd_last_q;
            end else begin
                ob1_data_d = rd_data_q;
                ob1_last_d = rd_last_q;
            end
            ob_cnt_d = ob_cnt_d + 2'd1;
        end
    end

    // NOTE: coefficient RAM and its read register carry no reset; nothing reads them before a write.
    always_ff @(posedge clk) begin
        if (ram_we) ram[wr_cnt_q[IDX_W-1:0]] <= fir_tap_wr_data_i;
        if (rd_issue) rd_data_q <= ram[rd_ptr_q[IDX_W-1:0]];
    end

    // NOTE: state is updated with non-blocking assignments only, so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_d1_q    <= 1'b0;
            wr_cnt_q    <= '0;
            bad_q       <= 1'b0;
            wr_addr_q   <= '0;
            rd_ptr_q    <= '0;
            rd_pend_q   <= 1'b0;
            rd_last_q   <= 1'b0;
            ob0_data_q  <= '0;
            ob0_last_q  <= 1'b0;
            ob1_data_q  <= '0;
            ob1_last_q  <= 1'b0;
            ob_cnt_q    <= 2'd0;
            done_q      <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            err_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_d1_q    <= fir_tap_wr_cmd_i;
            wr_cnt_q    <= wr_cnt_d;
            bad_q       <= bad_d;
            wr_addr_q   <= wr_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_pend_q   <= rd_pend_d;
            rd_last_q   <= rd_last_d;
            ob0_data_q  <= ob0_data_d;
            ob0_last_q  <= ob0_last_d;
            ob1_data_q  <= ob1_data_d;
            ob1_last_q  <= ob1_last_d;
            ob_cnt_q    <= ob_cnt_d;
            done_q      <= done_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            err_busy_q  <= err_busy_d;
        end
    end

endmodule

// File: tb/tb_fir_tap_wr_ctrl.sv
// Bench for fir_tap_wr_ctrl: random frames and arbiter handshakes checked against a
// frame-level model (queues of expected burst addresses/words and error-pulse counts).
module tb_fir_tap_wr_ctrl;

    localparam int          TAP_NUM    = 127;
    localparam int          DATA_W     = 32;
    localparam int          ADDR_W     = 32;
    localparam logic [31:0] DDR_BASE   = 32'h0100_0000;
    localparam int          TAP_STRIDE = 512;

    logic              clk;
    logic              rst_n;
    logic              fir_tap_wr_cmd_i;
    logic [31:0]       fir_tap_wr_addr_i;
    logic              fir_tap_wr_vld_i;
    logic [DATA_W-1:0] fir_tap_wr_data_i;
    logic              wr_req_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic              wr_ack_i;
    logic              wr_valid_o;
    logic [DATA_W-1:0] wr_data_o;
    logic              wr_last_o;
    logic              wr_ready_i;
    logic              busy_o;
    logic              done_o;
    logic              err_short_o;
    logic              err_long_o;
    logic              err_busy_o;

    fir_tap_wr_ctrl #(
        .TAP_NUM(TAP_NUM), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .DDR_BASE(DDR_BASE), .TAP_STRIDE(TAP_STRIDE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fir_tap_wr_cmd_i(fir_tap_wr_cmd_i), .fir_tap_wr_addr_i(fir_tap_wr_addr_i),
        .fir_tap_wr_vld_i(fir_tap_wr_vld_i), .fir_tap_wr_data_i(fir_tap_wr_data_i),
        .wr_req_o(wr_req_o), .wr_addr_o(wr_addr_o), .wr_ack_i(wr_ack_i),
        .wr_valid_o(wr_valid_o), .wr_data_o(wr_data_o), .wr_last_o(wr_last_o),
        .wr_ready_i(wr_ready_i), .busy_o(busy_o), .done_o(done_o),
        .err_short_o(err_short_o), .err_long_o(err_long_o), .err_busy_o(err_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: what the arbiter must see and how many pulses of each kind.
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int exp_hs = 0, exp_done = 0, exp_short = 0, exp_long = 0, exp_busy = 0;

    // Observations.
    int hs_cnt = 0, done_cnt = 0, short_cnt = 0, long_cnt = 0, busy_cnt = 0, req_cycles = 0;
    int obs_idx = 0;
    bit in_burst = 0;
    logic [31:0] last_hs_addr = '0;

    // Arbiter behaviour knobs.
    int ack_delay = 0;
    bit rdy_rand  = 0;

    int          req_wait = 0;
    bit          prev_req = 0, prev_ack = 0, prev_valid = 0, prev_ready = 0, prev_last = 0;
    logic [31:0] prev_addr = '0, prev_data = '0;
    bit          last_acc_prev = 0, lat_track = 0;
    int          lat = 0;

    task automatic clear_trackers();
        prev_req = 0; prev_ack = 0; prev_valid = 0; prev_ready = 0;
        last_acc_prev = 0; lat_track = 0; in_burst = 0; req_wait = 0;
    endtask

    // Arbiter emulation and burst monitor: drive ack/ready and sample outputs on the falling edge.
    initial begin
        wr_ack_i   = 1'b0;
        wr_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wr_ack_i   = 1'b0;
                wr_ready_i = 1'b0;
                clear_trackers();
                continue;
            end
            if (wr_req_o) begin
                wr_ack_i = (req_wait >= ack_delay);
                req_wait++;
            end else begin
                wr_ack_i = 1'($urandom_range(0, 1));
            end
            wr_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;

            if (prev_req && !prev_ack) begin
                check("req_held", wr_req_o, 1);
                check("addr_held", wr_addr_o, prev_addr);
            end
            if (prev_valid && !prev_ready) begin
                check("valid_held", wr_valid_o, 1);
                check("data_held", wr_data_o, prev_data);
                check("last_held", wr_last_o, prev_last);
            end
            if (last_acc_prev) check("done_after_last", done_o, 1);
            last_acc_prev = 0;
            if (lat_track) begin
                lat++;
                if (wr_valid_o || lat >= 3) begin
                    check("first_valid_latency", wr_valid_o && lat <= 2, 1);
                    lat_track = 0;
                end
            end

            if (wr_req_o) req_cycles++;
            if (wr_req_o && wr_ack_i) begin
                hs_cnt++;
                req_wait     = 0;
                last_hs_addr = wr_addr_o;
                check("req_expected", exp_addr_q.size() != 0, 1);
                if (exp_addr_q.size() != 0) check("req_addr", wr_addr_o, exp_addr_q.pop_front());
                lat_track = 1;
                lat       = 0;
                obs_idx   = 0;
                in_burst  = 1;
            end
            if (wr_valid_o && wr_ready_i) begin
                check("word_expected", exp_data_q.size() != 0, 1);
                if (exp_data_q.size() != 0) check("burst_data", wr_data_o, exp_data_q.pop_front());
                check("last_flag", wr_last_o, obs_idx == TAP_NUM - 1);
                obs_idx++;
                if (wr_last_o) begin
                    last_acc_prev = 1;
                    in_burst      = 0;
                end
            end

            done_cnt  += int'(done_o);
            short_cnt += int'(err_short_o);
            long_cnt  += int'(err_long_o);
            busy_cnt  += int'(err_busy_o);

            prev_req   = wr_req_o;
            prev_ack   = wr_ack_i;
            prev_addr  = wr_addr_o;
            prev_valid = wr_valid_o;
            prev_ready = wr_ready_i;
            prev_data  = wr_data_o;
            prev_last  = wr_last_o;
        end
    end

    // One command frame of n words; the model records what the frame must produce.
    task automatic send_frame(input int idx, input int n, input bit ramp, input bit busy);
        logic [31:0] w;
        bit late_fall;
        late_fall = 1'($urandom_range(0, 1));
        if (busy) begin
            exp_busy++;
        end else if (n == TAP_NUM) begin
            exp_addr_q.push_back(DDR_BASE + 32'(idx) * 32'(TAP_STRIDE));
            exp_hs++;
            exp_done++;
        end else if (n < TAP_NUM) begin
            exp_short++;
        end else begin
            exp_long += n - TAP_NUM;
        end
        @(negedge clk);
        fir_tap_wr_cmd_i  = 1'b1;
        fir_tap_wr_addr_i = 32'(idx);
        fir_tap_wr_vld_i  = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            fir_tap_wr_addr_i = $urandom;
            while ($urandom_range(0, 3) == 0) begin
                fir_tap_wr_vld_i  = 1'b0;
                fir_tap_wr_data_i = $urandom;
                @(negedge clk);
            end
            w = ramp ? 32'(32'hABCD_0030 + i) : 32'($urandom);
            fir_tap_wr_vld_i  = 1'b1;
            fir_tap_wr_data_i = w;
            if (late_fall && i == n - 1) fir_tap_wr_cmd_i = 1'b0;
            if (!busy && n == TAP_NUM) exp_data_q.push_back(w);
        end
        @(negedge clk);
        fir_tap_wr_vld_i = 1'b0;
        fir_tap_wr_cmd_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (done_cnt < exp_done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, done_cnt, exp_done);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_burst(input int words);
        int cyc = 0;
        while (!(in_burst && obs_idx >= words) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("burst_reached", in_burst && obs_idx >= words, 1);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_handshakes"}, hs_cnt, exp_hs);
        check({tag, "_short"}, short_cnt, exp_short);
        check({tag, "_long"}, long_cnt, exp_long);
        check({tag, "_busy"}, busy_cnt, exp_busy);
        check({tag, "_done_cnt"}, done_cnt, exp_done);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req"}, wr_req_o, 0);
        check({tag, "_addr"}, wr_addr_o, 0);
        check({tag, "_valid"}, wr_valid_o, 0);
        check({tag, "_data"}, wr_data_o, 0);
        check({tag, "_last"}, wr_last_o, 0);
        check({tag, "_busy_o"}, busy_o, 0);
        check({tag, "_done_o"}, done_o, 0);
        check({tag, "_err_short"}, err_short_o, 0);
        check({tag, "_err_long"}, err_long_o, 0);
        check({tag, "_err_busy"}, err_busy_o, 0);
    endtask

    initial begin
        int req_before;
        rst_n             = 1'b0;
        fir_tap_wr_cmd_i  = 1'b0;
        fir_tap_wr_addr_i = '0;
        fir_tap_wr_vld_i  = 1'b0;
        fir_tap_wr_data_i = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Ramp frame at set 3, arbiter always ready.
        send_frame(3, TAP_NUM, 1, 0);
        wait_done("t1");
        check("t1_addr", last_hs_addr, 32'h0100_0600);
        check_counts("t1");

        // Same frame with a slow ack and random back-pressure.
        rdy_rand  = 1;
        ack_delay = 10;
        send_frame(3, TAP_NUM, 1, 0);
        wait_done("t2");
        check_counts("t2");

        // Short frame, then a good one.
        rdy_rand   = 0;
        ack_delay  = 0;
        req_before = req_cycles;
        send_frame(5, 100, 0, 0);
        repeat (10) @(negedge clk);
        check("t3_no_req", req_cycles, req_before);
        check_counts("t3a");
        rdy_rand  = 1;
        ack_delay = $urandom_range(0, 4);
        send_frame($urandom_range(0, 15), TAP_NUM, 0, 0);
        wait_done("t3b");
        check_counts("t3b");

        // Long frame.
        req_before = req_cycles;
        send_frame(9, TAP_NUM + 3, 0, 0);
        repeat (10) @(negedge clk);
        check("t4_no_req", req_cycles, req_before);
        check_counts("t4");

        // New frame arriving while a burst is in flight.
        ack_delay = $urandom_range(0, 3);
        send_frame(1, TAP_NUM, 0, 0);
        wait_burst(5);
        send_frame(7, 20, 0, 1);
        wait_done("t5");
        repeat (20) @(negedge clk);
        check_counts("t5");

        // Asynchronous reset in the middle of a burst.
        rdy_rand  = 0;
        ack_delay = 0;
        send_frame(2, TAP_NUM, 0, 0);
        wait_burst(60);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("async_rst");
        repeat (TAP_NUM - obs_idx) void'(exp_data_q.pop_front());
        exp_done--;
        obs_idx = 0;
        clear_trackers();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        send_frame(0, TAP_NUM, 0, 0);
        wait_done("t6");
        check("t6_addr", last_hs_addr, 32'h0100_0000);
        check_counts("t6");
        check("model_drained", exp_data_q.size() + exp_addr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
